axi3_read_arbiter: RTL

AXI3_READ_ARBITER -- requirements
Module: axi3_read_arbiter

---
 rtl/axi3_read_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/axi3_read_arbiter.sv
// Two-requester AXI3 read arbiter sharing one master read port.
// One burst in flight; beat-count mismatches and a watchdog raise a sticky error.
module axi3_read_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0,
    parameter int MAX_WAIT       = 1023
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic        s0_axi_arready,
    input  logic [3:0]  s0_axi_arlen,
    input  logic [31:0] s0_axi_araddr,
    input  logic        s0_axi_arvalid,
    output logic        s0_axi_rlast,
    output logic        s0_axi_rvalid,
    output logic [31:0] s0_axi_rdata,
    input  logic        s0_axi_rready,
    output logic        s1_axi_arready,
    input  logic [3:0]  s1_axi_arlen,
    input  logic [31:0] s1_axi_araddr,
    input  logic        s1_axi_arvalid,
    output logic        s1_axi_rlast,
    output logic        s1_axi_rvalid,
    output logic [31:0] s1_axi_rdata,
    input  logic        s1_axi_rready,
    input  logic        m00_axi_arready,
    output logic [3:0]  m00_axi_arlen,
    output logic [31:0] m00_axi_araddr,
    output logic        m00_axi_arvalid,
    input  logic        m00_axi_rlast,
    input  logic        m00_axi_rvalid,
    input  logic [31:0] m00_axi_rdata,
    output logic        m00_axi_rready,
    output logic [1:0]  GRANT,
    output logic        BURST_ERR,
    output logic [15:0] BURST_COUNT0,
    output logic [15:0] BURST_COUNT1
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [9:0] WAIT_LAST = 10'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_q, last_d;
    logic [4:0]  expected_q, expected_d;
    logic [4:0]  beats_q, beats_d;
    logic [9:0]  wait_q, wait_d;
    logic        err_q, err_d;
    logic [15:0] count0_q, count0_d;
    logic [15:0] count1_q, count1_d;
    logic        sel1, pick1, in_addr, in_data, beat;
    logic [4:0]  beats_next;

    assign sel1       = grant_q[1];
    assign in_addr    = (state_q == ADDR);
    assign in_data    = (state_q == DATA);
    assign beat       = in_data & m00_axi_rvalid & m00_axi_rready;
    assign beats_next = beats_q + 5'd1;

    // last_q set means port 1 owned the previous completed burst
    assign pick1 = s1_axi_arvalid &
                   (~s0_axi_arvalid | (~FIXED_PRIORITY & ~last_q));

    assign m00_axi_arvalid = in_addr;
    assign m00_axi_araddr  = sel1 ? s1_axi_araddr : s0_axi_araddr;
    assign m00_axi_arlen   = sel1 ? s1_axi_arlen : s0_axi_arlen;
    assign m00_axi_rready  = in_data & (sel1 ? s1_axi_rready : s0_axi_rready);

    assign s0_axi_arready = in_addr & grant_q[0] & m00_axi_arready;
    assign s1_axi_arready = in_addr & grant_q[1] & m00_axi_arready;
    assign s0_axi_rvalid  = in_data & grant_q[0] & m00_axi_rvalid;
    assign s1_axi_rvalid  = in_data & grant_q[1] & m00_axi_rvalid;
    assign s0_axi_rlast   = in_data & grant_q[0] & m00_axi_rlast;
    assign s1_axi_rlast   = in_data & grant_q[1] & m00_axi_rlast;
    assign s0_axi_rdata   = (in_data & grant_q[0]) ? m00_axi_rdata : '0;
    assign s1_axi_rdata   = (in_data & grant_q[1]) ? m00_axi_rdata : '0;

    assign GRANT        = grant_q;
    assign BURST_ERR    = err_q;
    assign BURST_COUNT0 = count0_q;
    assign BURST_COUNT1 = count1_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        expected_d = expected_q;
        beats_d    = beats_q;
        wait_d     = wait_q;
        err_d      = err_q;
        count0_d   = count0_q;
        count1_d   = count1_q;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (s0_axi_arvalid | s1_axi_arvalid) begin
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                wait_d = wait_q + 10'd1;
                if (m00_axi_arready) begin
                    expected_d = {1'b0, m00_axi_arlen} + 5'd1;
                    beats_d    = '0;
                    state_d    = DATA;
                end
                if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            DATA: begin
                wait_d = wait_q + 10'd1;
                if (beat) begin
                    beats_d = beats_next;
                    if (m00_axi_rlast) begin
                        if (beats_next != expected_q)
                            err_d = 1'b1;
                        last_d  = sel1;
                        grant_d = '0;
                        state_d = IDLE;
                        if (sel1) count1_d = count1_q + 16'd1;
                        else      count0_d = count0_q + 16'd1;
                    end else if (beats_next == expected_q) begin
                        err_d = 1'b1;
                    end
                end
                // a burst completing on the same edge wins over the watchdog
                if (wait_q == WAIT_LAST && !(beat && m00_axi_rlast)) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= 1'b1;
            expected_q <= '0;
            beats_q    <= '0;
            wait_q     <= '0;
            err_q      <= 1'b0;
            count0_q   <= '0;
            count1_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            expected_q <= expected_d;
            beats_q    <= beats_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
            count0_q   <= count0_d;
            count1_q   <= count1_d;
        end
    end
endmodule
